// File: rtl/fetch_if.sv
// fetch_if: handshake/bus bundle between the fetch unit and its environment.
//   start          : pulse that starts fetching from IDLE
//   imem_pc        : ROM address (fetch unit -> ROM)
//   imem_inst      : combinational ROM word for imem_pc
//   inst_out/pc    : instruction and its address presented to decode
//   inst_valid     : output register holds an instruction
//   inst_ready     : decode accepts the instruction this cycle
//   branch_taken   : one-cycle redirect request from execute
//   branch_target  : redirect address
//   halted         : halt instruction consumed, fetch stopped
// The master modport is the environment; the slave modport is the fetch unit.
interface fetch_if #(
    parameter int PC_W   = 8,
    parameter int INST_W = 9
);
    logic              start;
    logic [PC_W-1:0]   imem_pc;
    logic [INST_W-1:0] imem_inst;
    logic [INST_W-1:0] inst_out;
    logic [PC_W-1:0]   inst_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic              branch_taken;
    logic [PC_W-1:0]   branch_target;
    logic              halted;
    modport master (
        output start, imem_inst, inst_ready, branch_taken, branch_target,
        input  imem_pc, inst_out, inst_pc, inst_valid, halted
    );
    modport slave (
        input  start, imem_inst, inst_ready, branch_taken, branch_target,
        output imem_pc, inst_out, inst_pc, inst_valid, halted
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with a one-entry valid/ready output register.
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset, clears all state
//   bus   : fetch_if.slave (ROM address/data, decode handshake, branch redirect, halted)
// Optional: define FETCH_WRAP_HALT_EN to stop fetching after the word at the
// last address instead of wrapping the PC to 0.
module fetch_unit #(
    parameter int                PC_W      = 8,
    parameter int                INST_W    = 9,
    parameter logic [PC_W-1:0]   START_PC  = '0,
    parameter logic [INST_W-1:0] HALT_INST = 9'h1FF
) (
    input  logic i_clk,
    input  logic i_rst,
    fetch_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALT} state_t;
    state_t            r_state, w_state;
    logic [PC_W-1:0]   r_pc, w_pc;
    logic [INST_W-1:0] r_inst, w_inst;
    logic [PC_W-1:0]   r_inst_pc, w_inst_pc;
    logic              r_valid, w_valid;
    logic              r_halted, w_halted;
    logic              w_fill, w_xfer, w_is_halt, w_stop;
    assign w_fill    = !r_valid || bus.inst_ready;
    assign w_xfer    = r_valid && bus.inst_ready;
    assign w_is_halt = bus.imem_inst == HALT_INST;
`ifdef FETCH_WRAP_HALT_EN
    // The last address is treated like a halt so the PC never wraps.
    assign w_stop = w_is_halt || (r_pc == {PC_W{1'b1}});
`else
    assign w_stop = w_is_halt;
`endif
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_pc      <= START_PC;
            r_inst    <= '0;
            r_inst_pc <= '0;
            r_valid   <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_pc      <= w_pc;
            r_inst    <= w_inst;
            r_inst_pc <= w_inst_pc;
            r_valid   <= w_valid;
            r_halted  <= w_halted;
        end
    end
    // Branch is checked first in RUN/DRAIN so it overrides fill and transfer.
    always_comb begin
        w_state   = r_state;
        w_pc      = r_pc;
        w_inst    = r_inst;
        w_inst_pc = r_inst_pc;
        w_valid   = r_valid;
        w_halted  = r_halted;
        case (r_state)
            S_IDLE: w_state = bus.start ? S_RUN : S_IDLE;
            S_RUN: begin
                if (bus.branch_taken) begin
                    w_valid = 1'b0;
                    w_pc    = bus.branch_target;
                end else if (w_fill) begin
                    w_inst    = bus.imem_inst;
                    w_inst_pc = r_pc;
                    w_valid   = 1'b1;
                    w_pc      = w_stop ? r_pc : r_pc + PC_W'(1);
                    w_state   = w_stop ? S_DRAIN : S_RUN;
                end else if (w_xfer) begin
                    w_valid = 1'b0;
                end
            end
            S_DRAIN: begin
                if (bus.branch_taken) begin
                    w_valid = 1'b0;
                    w_pc    = bus.branch_target;
                    w_state = S_RUN;
                end else if (w_xfer) begin
                    w_valid  = 1'b0;
                    w_halted = 1'b1;
                    w_state  = S_HALT;
                end
            end
            default: w_state = S_HALT;
        endcase
    end
    assign bus.imem_pc    = r_pc;
    assign bus.inst_out   = r_inst;
    assign bus.inst_pc    = r_inst_pc;
    assign bus.inst_valid = r_valid;
    assign bus.halted     = r_halted;
endmodule
